// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and helpers for the pipe_reg_chain block.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int MODE_RIGID   = 0;
    localparam int MODE_ELASTIC = 1;

    // Width of a counter that can hold every value from 0 to depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One slot of the register chain: valid bit plus data word.
//                The advance enable comes from the parent so that the same
//                slot serves both the rigid and the elastic chain.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_src_v,
    input  logic [WIDTH-1:0] i_src_d,
    output logic             o_v,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v_next
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic             w_v_next;
    logic             w_load_d;

    // Next valid bit: flush clears, advance takes the source, otherwise hold.
    always_comb begin
        w_v_next = r_v;
        w_load_d = 1'b0;
        if (i_flush) begin
            w_v_next = 1'b0;
        end else if (i_adv) begin
            w_v_next = i_src_v;
            // Bubbles moving in leave the stale data word untouched.
            w_load_d = i_src_v;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_d <= RESET_VAL;
        end else begin
            r_v <= w_v_next;
            if (w_load_d) begin
                r_d <= i_src_d;
            end
        end
    end

    assign o_v      = r_v;
    assign o_d      = r_d;
    assign o_v_next = w_v_next;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : DEPTH-stage stallable register chain with per-stage valid,
//                flush, ready/valid input handshake and occupancy count.
//                MODE selects rigid (whole chain freezes on stall) or
//                elastic (bubbles collapse behind a stalled output).
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter int               MODE      = MODE_RIGID,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data_input,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             data_output,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int c_occ_w = occ_width(DEPTH);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be in 1..16");
    end

    logic [DEPTH-1:0]   w_v;
    logic [DEPTH-1:0]   w_v_next;
    logic [DEPTH-1:0]   w_adv;
    logic [DEPTH-1:0]   w_src_v;
    logic [WIDTH-1:0]   w_d     [DEPTH];
    logic [WIDTH-1:0]   w_src_d [DEPTH];
    logic               w_accept;
    logic               w_chain;
    logic [c_occ_w-1:0] w_occ_next;
    logic [c_occ_w-1:0] r_occ;

    // Advance enables: rigid freezes everything on stall; elastic lets a
    // stage move whenever anything downstream of it moves or it is a bubble.
    always_comb begin
        w_adv   = '0;
        w_chain = 1'b0;
        if (MODE == MODE_ELASTIC) begin
            w_chain          = ~stall | ~w_v[DEPTH-1];
            w_adv[DEPTH-1]   = w_chain;
            for (int i = DEPTH - 2; i >= 0; i--) begin
                w_chain  = w_chain | ~w_v[i];
                w_adv[i] = w_chain;
            end
        end else begin
            w_adv = {DEPTH{~stall}};
        end
    end

    assign in_ready = w_adv[0] & ~flush;
    assign w_accept = in_valid & in_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_src_v[gi] = w_accept;
            assign w_src_d[gi] = data_input;
        end else begin : g_body
            assign w_src_v[gi] = w_v[gi-1];
            assign w_src_d[gi] = w_d[gi-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_flush  (flush),
            .i_adv    (w_adv[gi]),
            .i_src_v  (w_src_v[gi]),
            .i_src_d  (w_src_d[gi]),
            .o_v      (w_v[gi]),
            .o_d      (w_d[gi]),
            .o_v_next (w_v_next[gi])
        );
    end

    // Popcount of the next valid vector so occupancy tracks v on the same edge.
    always_comb begin
        w_occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_next = w_occ_next + c_occ_w'(w_v_next[i]);
        end
    end

    // Occupancy register, cleared with the valid bits on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    assign occupancy   = r_occ;
    assign out_valid   = w_v[DEPTH-1];
    assign data_output = w_d[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_chain
//  Description : Directed self-checking bench for pipe_reg_chain. Three
//                instances share stimulus: rigid DEPTH=3, elastic DEPTH=3
//                and rigid DEPTH=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       in_valid;
    logic [7:0] data_input;

    logic       rg_in_ready, rg_out_valid;
    logic [7:0] rg_data_output;
    logic [1:0] rg_occ;
    logic       el_in_ready, el_out_valid;
    logic [7:0] el_data_output;
    logic [1:0] el_occ;
    logic       d1_in_ready, d1_out_valid;
    logic [7:0] d1_data_output;
    logic [0:0] d1_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .MODE(pipe_pkg::MODE_RIGID), .RESET_VAL(8'h00)) u_rigid (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ready(rg_in_ready), .data_input(data_input), .out_valid(rg_out_valid),
        .data_output(rg_data_output), .occupancy(rg_occ));

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .MODE(pipe_pkg::MODE_ELASTIC), .RESET_VAL(8'h5A)) u_elastic (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ready(el_in_ready), .data_input(data_input), .out_valid(el_out_valid),
        .data_output(el_data_output), .occupancy(el_occ));

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .MODE(pipe_pkg::MODE_RIGID), .RESET_VAL(8'h33)) u_d1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ready(d1_in_ready), .data_input(data_input), .out_valid(d1_out_valid),
        .data_output(d1_data_output), .occupancy(d1_occ));

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; data_input = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rg_out_valid, rg_data_output, rg_occ, rg_in_ready} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_rigid: got v=%b d=%h occ=%0d rdy=%b exp v=0 d=00 occ=0 rdy=1",
                     rg_out_valid, rg_data_output, rg_occ, rg_in_ready);
        end
        checks++;
        if ({el_out_valid, el_data_output, el_occ, el_in_ready} !== {1'b0, 8'h5A, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_elastic: got v=%b d=%h occ=%0d rdy=%b exp v=0 d=5a occ=0 rdy=1",
                     el_out_valid, el_data_output, el_occ, el_in_ready);
        end
        checks++;
        if ({d1_out_valid, d1_data_output, d1_occ, d1_in_ready} !== {1'b0, 8'h33, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_d1: got v=%b d=%h occ=%0d rdy=%b exp v=0 d=33 occ=0 rdy=1",
                     d1_out_valid, d1_data_output, d1_occ, d1_in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [10:0] exp_rg [8];
        exp_rg[0] = {1'b0, 8'h00, 2'd1};
        exp_rg[1] = {1'b0, 8'h00, 2'd2};
        exp_rg[2] = {1'b1, 8'h01, 2'd3};
        exp_rg[3] = {1'b1, 8'h02, 2'd3};
        exp_rg[4] = {1'b1, 8'h03, 2'd3};
        exp_rg[5] = {1'b1, 8'h04, 2'd2};
        exp_rg[6] = {1'b1, 8'h05, 2'd1};
        exp_rg[7] = {1'b0, 8'h05, 2'd0};   // drained, stale data kept
        do_reset();
        for (int e = 0; e < 8; e++) begin
            in_valid   = (e < 5);
            data_input = 8'(e + 1);
            step();
            checks++;
            if ({rg_out_valid, rg_data_output, rg_occ} !== exp_rg[e]) begin
                errors++;
                $display("FAIL stream_edge%0d: got {v,d,occ}=%h exp %h", e + 1,
                         {rg_out_valid, rg_data_output, rg_occ}, exp_rg[e]);
            end
            if (e == 0) begin
                checks++;
                if ({d1_out_valid, d1_data_output, d1_occ} !== {1'b1, 8'h01, 1'b1}) begin
                    errors++;
                    $display("FAIL stream_d1_latency: got v=%b d=%h occ=%0d exp v=1 d=01 occ=1",
                             d1_out_valid, d1_data_output, d1_occ);
                end
            end
        end
    endtask

    task automatic test_rigid_stall();
        do_reset();
        in_valid = 1'b1; data_input = 8'd1; step();
        in_valid = 1'b0;                    step();
        in_valid = 1'b1; data_input = 8'd2; step();
        // Pipe now {s0=2, s1=bubble, s2=1}.
        stall = 1'b1; in_valid = 1'b1; data_input = 8'd7;
        #1;
        checks++;
        if (rg_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rigid_stall_ready: got %b exp 0", rg_in_ready);
        end
        for (int e = 0; e < 2; e++) begin
            step();
            checks++;
            if ({rg_out_valid, rg_data_output, rg_occ, rg_in_ready} !== {1'b1, 8'h01, 2'd2, 1'b0}) begin
                errors++;
                $display("FAIL rigid_stall_hold%0d: got v=%b d=%h occ=%0d rdy=%b exp v=1 d=01 occ=2 rdy=0",
                         e, rg_out_valid, rg_data_output, rg_occ, rg_in_ready);
            end
        end
        checks++;
        if ({d1_out_valid, d1_data_output} !== {1'b1, 8'h02}) begin
            errors++;
            $display("FAIL d1_stall_hold: got v=%b d=%h exp v=1 d=02", d1_out_valid, d1_data_output);
        end
        stall = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if ({rg_out_valid, rg_occ} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL rigid_release1: got v=%b occ=%0d exp v=0 occ=1", rg_out_valid, rg_occ);
        end
        step();
        checks++;
        if ({rg_out_valid, rg_data_output, rg_occ} !== {1'b1, 8'h02, 2'd1}) begin
            errors++;
            $display("FAIL rigid_release2: got v=%b d=%h occ=%0d exp v=1 d=02 occ=1",
                     rg_out_valid, rg_data_output, rg_occ);
        end
        step();
        checks++;
        if ({rg_out_valid, rg_occ} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL rigid_release3: got v=%b occ=%0d exp v=0 occ=0 (7 must not enter)",
                     rg_out_valid, rg_occ);
        end
    endtask

    task automatic test_elastic_collapse();
        do_reset();
        in_valid = 1'b1; data_input = 8'd1; step();
        in_valid = 1'b0;                    step();
        in_valid = 1'b1; data_input = 8'd2; step();
        checks++;
        if ({el_out_valid, el_data_output, el_occ} !== {1'b1, 8'h01, 2'd2}) begin
            errors++;
            $display("FAIL elastic_load: got v=%b d=%h occ=%0d exp v=1 d=01 occ=2",
                     el_out_valid, el_data_output, el_occ);
        end
        stall = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (el_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL elastic_ready_bubble: got %b exp 1", el_in_ready);
        end
        step();   // collapse: {bubble, 2, 1}
        checks++;
        if ({el_out_valid, el_data_output, el_occ, el_in_ready} !== {1'b1, 8'h01, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL elastic_collapse: got v=%b d=%h occ=%0d rdy=%b exp v=1 d=01 occ=2 rdy=1",
                     el_out_valid, el_data_output, el_occ, el_in_ready);
        end
        in_valid = 1'b1; data_input = 8'd3;
        step();   // {3, 2, 1}
        checks++;
        if ({el_out_valid, el_data_output, el_occ, el_in_ready} !== {1'b1, 8'h01, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL elastic_full: got v=%b d=%h occ=%0d rdy=%b exp v=1 d=01 occ=3 rdy=0",
                     el_out_valid, el_data_output, el_occ, el_in_ready);
        end
        data_input = 8'd4;
        step();   // full and stalled: nothing moves, 4 refused
        stall = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if ({el_out_valid, el_data_output, el_occ} !== {1'b1, 8'h02, 2'd2}) begin
            errors++;
            $display("FAIL elastic_drain1: got v=%b d=%h occ=%0d exp v=1 d=02 occ=2",
                     el_out_valid, el_data_output, el_occ);
        end
        step();
        checks++;
        if ({el_out_valid, el_data_output, el_occ} !== {1'b1, 8'h03, 2'd1}) begin
            errors++;
            $display("FAIL elastic_drain2: got v=%b d=%h occ=%0d exp v=1 d=03 occ=1",
                     el_out_valid, el_data_output, el_occ);
        end
        step();
        checks++;
        if ({el_out_valid, el_occ} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL elastic_drain3: got v=%b occ=%0d exp v=0 occ=0 (4 must not enter)",
                     el_out_valid, el_occ);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            data_input = 8'(e);
            step();
        end
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; data_input = 8'd9;
        #1;
        checks++;
        if ({rg_in_ready, el_in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL flush_ready: got rg=%b el=%b exp 0 0", rg_in_ready, el_in_ready);
        end
        step();
        checks++;
        if ({rg_out_valid, rg_data_output, rg_occ} !== {1'b0, 8'h01, 2'd0}) begin
            errors++;
            $display("FAIL flush_rigid: got v=%b d=%h occ=%0d exp v=0 d=01 occ=0",
                     rg_out_valid, rg_data_output, rg_occ);
        end
        checks++;
        if ({el_out_valid, el_occ} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_elastic: got v=%b occ=%0d exp v=0 occ=0", el_out_valid, el_occ);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (el_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_only_ready: got %b exp 0", el_in_ready);
        end
        flush = 1'b0; in_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            checks++;
            if ({rg_out_valid, rg_occ, el_out_valid, el_occ} !== 6'b0) begin
                errors++;
                $display("FAIL flush_no_item%0d: got rg v=%b occ=%0d el v=%b occ=%0d exp all 0",
                         e, rg_out_valid, rg_occ, el_out_valid, el_occ);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            data_input = 8'(e);
            step();
        end
        rst_n = 1'b0; data_input = 8'd4;
        step();
        checks++;
        if ({rg_out_valid, rg_data_output, rg_occ} !== {1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL midreset_rigid: got v=%b d=%h occ=%0d exp v=0 d=00 occ=0",
                     rg_out_valid, rg_data_output, rg_occ);
        end
        checks++;
        if ({el_out_valid, el_data_output, el_occ, d1_data_output} !== {1'b0, 8'h5A, 2'd0, 8'h33}) begin
            errors++;
            $display("FAIL midreset_other: got el v=%b d=%h occ=%0d d1 d=%h exp 0 5a 0 33",
                     el_out_valid, el_data_output, el_occ, d1_data_output);
        end
        rst_n = 1'b1; in_valid = 1'b1; data_input = 8'd5;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({rg_out_valid, rg_occ} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL midreset_early: got v=%b occ=%0d exp v=0 occ=1", rg_out_valid, rg_occ);
        end
        step();
        checks++;
        if ({rg_out_valid, rg_data_output, rg_occ} !== {1'b1, 8'h05, 2'd1}) begin
            errors++;
            $display("FAIL midreset_emerge: got v=%b d=%h occ=%0d exp v=1 d=05 occ=1",
                     rg_out_valid, rg_data_output, rg_occ);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; data_input = 8'h00;
        test_reset();
        test_streaming();
        test_rigid_stall();
        test_elastic_collapse();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
